// File: rtl/stream_narrow_framed.sv
// Frame-aware narrowing word FIFO: wide input beats in, narrow output beats out.
// A last input beat switches to draining, which ends the frame with a zero-padded, flagged beat.
module stream_narrow_framed #(
    parameter int WORD_W      = 8,
    parameter int IN_WORDS    = 32,
    parameter int OUT_WORDS   = 3,
    parameter int DEPTH_WORDS = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [IN_WORDS*WORD_W-1:0]       stream_in,
    input  logic                             stream_in_valid,
    output logic                             stream_in_ready,
    input  logic                             stream_in_last,
    input  logic [$clog2(IN_WORDS+1)-1:0]    stream_in_nwords,
    output logic [OUT_WORDS*WORD_W-1:0]      stream_out,
    output logic                             stream_out_valid,
    input  logic                             stream_out_ready,
    output logic                             stream_out_last,
    output logic [$clog2(OUT_WORDS+1)-1:0]   stream_out_nwords
);
    localparam int PW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int LW     = $clog2(DEPTH_WORDS + 1);
    localparam int INW    = $clog2(IN_WORDS + 1);
    localparam int ONW    = $clog2(OUT_WORDS + 1);
    localparam int IXW    = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
    localparam int IN_PAD = 1 << IXW;

    localparam logic [LW-1:0]  OUT_L     = LW'(OUT_WORDS);
    localparam logic [LW-1:0]  IN_L      = LW'(IN_WORDS);
    localparam logic [LW-1:0]  RDY_MAX_L = LW'(DEPTH_WORDS - IN_WORDS);
    localparam logic [LW:0]    DEPTH_L   = (LW+1)'(DEPTH_WORDS);
    localparam logic [INW-1:0] IN_N      = INW'(IN_WORDS);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   lvl_q, lvl_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [WORD_W-1:0] in_word [IN_PAD];
    logic [LW:0]     wr_off [DEPTH_WORDS];

    logic            fire_in, fire_out, last_c;
    logic [LW-1:0]   n_push, n_out;

    // Wrapping add for pointers; DEPTH_WORDS need not be a power of two.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [LW-1:0] inc);
        logic [LW:0] s;
        s = (LW+1)'(p) + (LW+1)'(inc);
        if (s >= DEPTH_L) begin
            s = s - DEPTH_L;
        end
        return PW'(s);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < IN_PAD; gi++) begin : g_in_word
            if (gi < IN_WORDS) begin : g_real
                assign in_word[gi] = stream_in[gi*WORD_W +: WORD_W];
            end else begin : g_pad
                assign in_word[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        stream_in_ready = !rst && (state_q == FILL) && (lvl_q <= RDY_MAX_L);
        fire_in         = stream_in_valid && stream_in_ready;
        n_push          = IN_L;
        if (stream_in_last) begin
            n_push = (stream_in_nwords > IN_N) ? IN_L : LW'(stream_in_nwords);
        end

        if (state_q == DRAIN) begin
            stream_out_valid = 1'b1;
            last_c           = (lvl_q <= OUT_L);
            n_out            = last_c ? lvl_q : OUT_L;
        end else begin
            stream_out_valid = (lvl_q >= OUT_L);
            last_c           = 1'b0;
            n_out            = OUT_L;
        end
        stream_out_last   = stream_out_valid && last_c;
        stream_out_nwords = stream_out_valid ? ONW'(n_out) : '0;
        fire_out          = stream_out_valid && stream_out_ready;

        lvl_d    = lvl_q + (fire_in ? n_push : '0) - (fire_out ? n_out : '0);
        wr_ptr_d = fire_in  ? ptr_add(wr_ptr_q, n_push) : wr_ptr_q;
        rd_ptr_d = fire_out ? ptr_add(rd_ptr_q, n_out)  : rd_ptr_q;
        state_d  = state_q;
        if (fire_in && stream_in_last) begin
            state_d = DRAIN;
        end
        if (fire_out && last_c) begin
            state_d = FILL;
            lvl_d   = '0;
        end
    end

    // Distance of each buffer slot from the write pointer selects which input word lands there.
    always_comb begin
        for (int j = 0; j < DEPTH_WORDS; j++) begin
            wr_off[j] = (LW+1)'(j) + DEPTH_L - (LW+1)'(wr_ptr_q);
            if (wr_off[j] >= DEPTH_L) begin
                wr_off[j] = wr_off[j] - DEPTH_L;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < DEPTH_WORDS; j++) begin
            if (fire_in && (wr_off[j] < (LW+1)'(n_push))) begin
                mem[j] <= in_word[wr_off[j][IXW-1:0]];
            end
        end
    end

    generate
        for (gi = 0; gi < OUT_WORDS; gi++) begin : g_out
            logic [PW-1:0] rd_addr;
            assign rd_addr = ptr_add(rd_ptr_q, LW'(gi));
            assign stream_out[gi*WORD_W +: WORD_W] =
                (stream_out_valid && (LW'(gi) < n_out)) ? mem[rd_addr] : '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FILL;
            lvl_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            lvl_q    <= lvl_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule
